// File: rtl/gate_identifier.sv
// Two-input gate identifier: drives every {A,B} combination into the gate under
// test, captures its truth table and decodes it to a gate code.
module gate_identifier #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [3:0] gate_id
);

  typedef enum logic [1:0] {IDLE, DRIVE, DECODE} state_t;

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic       drv_a_q, drv_a_d;
  logic       drv_b_q, drv_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] tt_q, tt_d;
  logic [3:0] id_q, id_d;

  // Table bits are f(11) f(10) f(01) f(00); constants and unlisted patterns map to 0.
  function automatic logic [3:0] decode(input logic [3:0] tt);
    case (tt)
      4'b1000: decode = 4'd1;
      4'b0111: decode = 4'd2;
      4'b1110: decode = 4'd3;
      4'b0001: decode = 4'd4;
      4'b0110: decode = 4'd5;
      4'b1001: decode = 4'd6;
      4'b0011: decode = 4'd7;
      4'b0101: decode = 4'd8;
      default: decode = 4'd0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    drv_a_d  = drv_a_q;
    drv_b_d  = drv_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tt_d     = tt_q;
    id_d     = id_q;
    case (state_q)
      IDLE: begin
        drv_a_d = 1'b0;
        drv_b_d = 1'b0;
        if (start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          cnt_d   = SETTLE;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          shadow_d[idx_q] = gate_out;
          if (idx_q != 2'd3) begin
            idx_d              = idx_q + 2'd1;
            cnt_d              = SETTLE;
            {drv_a_d, drv_b_d} = idx_q + 2'd1;
          end else begin
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        tt_d    = shadow_q;
        id_d    = decode(shadow_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        drv_a_d = 1'b0;
        drv_b_d = 1'b0;
        idx_d   = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      drv_a_q  <= 1'b0;
      drv_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tt_q     <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      drv_a_q  <= drv_a_d;
      drv_b_q  <= drv_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tt_q     <= tt_d;
      id_q     <= id_d;
    end
  end

  assign drv_a       = drv_a_q;
  assign drv_b       = drv_b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign gate_id     = id_q;

endmodule

// File: tb/tb_gate_identifier.sv
// Bench for gate_identifier: directed and random gate runs on a SETTLE=2 and a
// SETTLE=0 instance, compared cycle by cycle against a truth-table model.
module tb_gate_identifier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s    [2];
  logic       gate_out_s [2];
  logic       drv_a_s    [2];
  logic       drv_b_s    [2];
  logic       busy_s     [2];
  logic       done_s     [2];
  logic [3:0] tt_s       [2];
  logic [3:0] id_s       [2];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned done_cyc [2];
  logic [3:0]  prev_tt  [2];
  logic [3:0]  prev_id  [2];

  gate_identifier #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .gate_out(gate_out_s[0]),
    .drv_a(drv_a_s[0]), .drv_b(drv_b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .truth_table(tt_s[0]), .gate_id(id_s[0])
  );

  gate_identifier #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_s[1]), .gate_out(gate_out_s[1]),
    .drv_a(drv_a_s[1]), .drv_b(drv_b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .truth_table(tt_s[1]), .gate_id(id_s[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate selectors: 0 AND 1 NAND 2 OR 3 NOR 4 XOR 5 XNOR 6 NOT_A 7 NOT_B 8 const1 9 const0
  function automatic logic gate_eval(input int g, input logic a, input logic b);
    case (g)
      0:       return a & b;
      1:       return ~(a & b);
      2:       return a | b;
      3:       return ~(a | b);
      4:       return a ^ b;
      5:       return ~(a ^ b);
      6:       return ~a;
      7:       return ~b;
      8:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_tt(input int g);
    logic [3:0] t;
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v    = 2'(i);
      t[i] = gate_eval(g, v[1], v[0]);
    end
    return t;
  endfunction

  function automatic logic [3:0] model_id(input logic [3:0] t);
    logic [3:0] known [8] = '{4'b1000, 4'b0111, 4'b1110, 4'b0001,
                              4'b0110, 4'b1001, 4'b0011, 4'b0101};
    for (int i = 0; i < 8; i++)
      if (known[i] == t) return 4'(i + 1);
    return 4'd0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full run on instance u. Called just after a posedge; returns just after the done edge
  // (plus one idle cycle unless start is held for back-to-back runs).
  task automatic run(input int u, input int g, input bit glitch, input bit extra, input bit hold);
    int unsigned p, last;
    logic [3:0]  exp_tt, exp_id, old_tt, old_id;
    logic [1:0]  v;
    p      = (u == 0) ? 3 : 1;
    last   = 4 * p + 1;
    exp_tt = model_tt(g);
    exp_id = model_id(exp_tt);
    old_tt = prev_tt[u];
    old_id = prev_id[u];
    start_s[u]    = 1'b1;
    gate_out_s[u] = gate_eval(g, drv_a_s[u], drv_b_s[u]);
    @(posedge clk); #1;
    if (!hold) start_s[u] = 1'b0;
    chk("accept_busy", 8'(busy_s[u]), 8'd1);
    chk("accept_drv", 8'({drv_a_s[u], drv_b_s[u]}), 8'd0);
    chk("accept_done", 8'(done_s[u]), 8'd0);
    for (int unsigned t = 1; t <= last; t++) begin
      gate_out_s[u] = gate_eval(g, drv_a_s[u], drv_b_s[u]) ^ (glitch && (t % p != 0));
      if (!hold) start_s[u] = (extra && t < last) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      v = (t >= last) ? 2'd0 : (t < 4 * p) ? 2'(t / p) : 2'd3;
      chk("drv", 8'({drv_a_s[u], drv_b_s[u]}), 8'(v));
      chk("busy", 8'(busy_s[u]), 8'(t < last));
      chk("done", 8'(done_s[u]), 8'(t == last));
      chk("truth_table", 8'(tt_s[u]), 8'((t == last) ? exp_tt : old_tt));
      chk("gate_id", 8'(id_s[u]), 8'((t == last) ? exp_id : old_id));
    end
    done_cyc[u] = cyc;
    prev_tt[u]  = exp_tt;
    prev_id[u]  = exp_id;
    if (!hold) begin
      start_s[u] = 1'b0;
      @(posedge clk); #1;
      chk("post_done", 8'(done_s[u]), 8'd0);
      chk("post_busy", 8'(busy_s[u]), 8'd0);
    end
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; gate_out_s[i] = 1'b0; prev_tt[i] = '0; prev_id[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_drv", 8'({drv_a_s[i], drv_b_s[i]}), 8'd0);
      chk("rst_busy", 8'(busy_s[i]), 8'd0);
      chk("rst_done", 8'(done_s[i]), 8'd0);
      chk("rst_tt", 8'(tt_s[i]), 8'd0);
      chk("rst_id", 8'(id_s[i]), 8'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed gate sweep, SETTLE=2
    run(0, 0, 0, 0, 0);  // AND
    run(0, 4, 0, 0, 0);  // XOR
    run(0, 5, 0, 0, 0);  // XNOR
    run(0, 3, 0, 0, 0);  // NOR
    run(0, 6, 0, 0, 0);  // NOT_A
    run(0, 7, 0, 0, 0);  // NOT_B
    run(0, 8, 0, 0, 0);  // constant 1 -> unknown
    run(0, 2, 0, 0, 0);  // OR overwrites only at done
    run(0, 9, 0, 0, 0);  // constant 0
    run(0, 1, 1, 0, 0);  // NAND with glitches off sample edges
    run(0, 6, 0, 1, 0);  // extra starts while busy

    // Back-to-back with start held
    run(0, 0, 0, 0, 1);
    c0 = done_cyc[0];
    run(0, 4, 0, 0, 1);
    start_s[0] = 1'b0;
    chk("b2b_period", 8'(done_cyc[0] - c0), 8'd14);
    @(posedge clk); #1;
    chk("b2b_idle_busy", 8'(busy_s[0]), 8'd0);

    // SETTLE=0 runs
    run(1, 0, 0, 0, 0);
    run(1, 5, 0, 1, 0);

    // Reset mid-run at edge N+7
    start_s[0]    = 1'b1;
    gate_out_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_drv", 8'({drv_a_s[0], drv_b_s[0]}), 8'd0);
    chk("midrst_busy", 8'(busy_s[0]), 8'd0);
    chk("midrst_done", 8'(done_s[0]), 8'd0);
    chk("midrst_tt", 8'(tt_s[0]), 8'd0);
    chk("midrst_id", 8'(id_s[0]), 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_tt[0] = '0; prev_id[0] = '0;
    prev_tt[1] = '0; prev_id[1] = '0;
    @(posedge clk); #1;
    chk("after_rst_done", 8'(done_s[0]), 8'd0);
    run(0, 2, 0, 0, 0);

    // Randomized runs
    for (int k = 0; k < 8; k++)
      run(k % 2, int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_identifier.md
Name: gate_identifier

Overview:
- Inverse of the two-input gate bank: drives A/B stimulus into one gate output under test and reads back its response.
- Sweeps all four input combinations, captures the 4-bit truth table, and decodes it to a gate code.
- Sits beside the gate bank as a self-check / lab-identification engine; one output of the bank at a time is wired to gate_out.

Parameters:
- SETTLE_CYCLES, 2, extra cycles each stimulus vector is held before sampling gate_out; legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- gate_out  input  1  response of the gate under test.
- drv_a  output  1  stimulus to gate input A (registered).
- drv_b  output  1  stimulus to gate input B (registered).
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when results are updated.
- truth_table  output  4  captured responses; bit i = gate_out for {A,B} = i.
- gate_id  output  4  decoded gate code.

Behaviour:
- Reset values: drv_a=0, drv_b=0, busy=0, done=0, truth_table=0, gate_id=0. FSM goes to IDLE, the vector index to 0, and the settle counter to 0.
- States:
  - IDLE: drv_a/drv_b=0. On start=1 at edge N, go to DRIVE with vector 0, load counter=SETTLE_CYCLES, and set busy=1 at edge N.
  - DRIVE: {drv_a,drv_b} = index (00, 01, 10, 11, in that order), held stable for SETTLE_CYCLES+1 cycles.
    - The counter decrements each cycle.
    - On the edge where the counter is 0, gate_out is sampled into the shadow table bit[index].
    - If index<3, increment the index, reload the counter, and drive the next vector on that same edge.
    - If index==3, go to DECODE.
  - DECODE: for one cycle, truth_table and gate_id are updated from the shadow table on the exiting edge, along with done=1, busy=0, drv_a/drv_b=0, and a return to IDLE.
- done is high exactly one cycle, then returns to 0.
- Timing: samples at edges N+k(S+1) for k=1..4, where S=SETTLE_CYCLES; results and done at edge N+4(S+1)+1.
  - S=2: samples at N+3, N+6, N+9, N+12; done at N+13.
  - S=0: total run time is 5 cycles.
- Decode (truth_table bits [3:0] = f(11) f(10) f(01) f(00)):
  - 1000 -> 1 AND
  - 0111 -> 2 NAND
  - 1110 -> 3 OR
  - 0001 -> 4 NOR
  - 0110 -> 5 XOR
  - 1001 -> 6 XNOR
  - 0011 -> 7 NOT_A
  - 0101 -> 8 NOT_B
  - any other pattern -> 0 UNKNOWN, including constants 0000 and 1111.
- Results hold their last values until the next run completes; they are not cleared at start.
- start while busy is ignored and not queued. start held high continuously gives back-to-back runs, each beginning the cycle after returning to IDLE.
- gate_out is ignored except on sample edges.
- Reset mid-run: immediate return to reset values; the partial table is discarded and no done pulse is produced.

Test Plan:
- Reset, then SETTLE_CYCLES=2, gate_out driven combinationally as drv_a&drv_b, start pulse at edge N -> drv sequence 00,01,10,11 each 3 cycles; done at N+13; truth_table=1000, gate_id=1.
- Repeat the run with gate_out = XOR, then XNOR, NOR, NOT_A (~drv_a), NOT_B (~drv_b) -> gate_id 5, 6, 4, 7, 8 respectively; truth_table 0110, 1001, 0001, 0011, 0101.
- gate_out tied to 1 -> truth_table=1111, gate_id=0. Then gate_out = OR -> gate_id=3, proving the previous result is overwritten only at done.
- gate_out glitches to the wrong value on non-sample cycles but is correct (NAND) on sample edges -> gate_id=2.
- Extra start pulses during busy -> no effect on timing, exactly one done. With start held high -> done pulses every 4(S+1)+2 cycles.
- Assert rst at edge N+7 of a run -> all outputs 0 asynchronously, no done pulse. Release rst and restart -> normal result.
